// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch/decode/issue FSM with JMP, BSR and RTS handled locally.
// Optional FETCH_STACK_CHECK_EN traps return-stack over/underflow into a sticky FAULT state.
module fetch_unit #(
  parameter int RAM_WIDTH   = 22,
  parameter int ADDR_SIZE   = 11,
  parameter int STACK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_rd_enb,
  input  logic [RAM_WIDTH-1:0] ram_data,
  output logic [RAM_WIDTH-1:0] instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [9:0]           instr_pc,
  output logic                 fault
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);
`ifdef FETCH_STACK_CHECK_EN
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
`endif

  localparam logic [3:0] OP_SYS  = 4'b0000;
  localparam logic [3:0] OP_BSR  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [2:0] SUB_RTS = 3'b011;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    ISSUE,
    FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [9:0]             pc_q, pc_d;
  logic [SP_W-1:0]        sp_q, sp_d;
  logic [RAM_WIDTH-1:0]   instr_q, instr_d;
  logic [9:0]             instr_pc_q, instr_pc_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [9:0]             stack_q [STACK_DEPTH];

  logic                   push_en;
  logic [IDX_W-1:0]       push_idx;
  logic [IDX_W-1:0]       pop_idx;
  logic [SP_W-1:0]        sp_inc;
  logic [SP_W-1:0]        sp_dec;
  logic [3:0]             opcode;
  logic [9:0]             field;
  logic [2:0]             sub;
  logic [9:0]             pc_inc;
  logic [9:0]             pc_rel;
  logic                   is_rts;

`ifdef FETCH_STACK_CHECK_EN
  logic                   fault_q, fault_d;
`endif

  assign opcode = ram_data[21:18];
  assign field  = ram_data[17:8];
  assign sub    = ram_data[17:15];
  assign is_rts = (opcode == OP_SYS) && (sub == SUB_RTS);

  // 10-bit adders give the mod-1024 wrap for free.
  assign pc_inc = pc_q + 10'd1;
  assign pc_rel = pc_q + field;

`ifdef FETCH_STACK_CHECK_EN
  assign sp_inc = sp_q + 1'b1;
  assign sp_dec = sp_q - 1'b1;
`else
  assign sp_inc = (sp_q == SP_LAST) ? '0 : sp_q + 1'b1;
  assign sp_dec = (sp_q == '0) ? SP_LAST : sp_q - 1'b1;
`endif

  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = sp_dec[IDX_W-1:0];

  // The read strobe must be asserted in the same cycle as the FETCH decision,
  // so it is decoded from state and en rather than registered.
  assign ram_rd_enb = (state_q == FETCH) && en && !rst;
  assign ram_addr   = ram_rd_enb ? ADDR_SIZE'(pc_q) : '0;

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

`ifdef FETCH_STACK_CHECK_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    sp_d          = sp_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    push_en       = 1'b0;
`ifdef FETCH_STACK_CHECK_EN
    fault_d       = fault_q;
`endif

    unique case (state_q)
      FETCH: begin
        if (en) state_d = DECODE;
      end

      DECODE: begin
        if (opcode == OP_JMP) begin
          pc_d    = field;
          state_d = FETCH;
        end else if (opcode == OP_BSR) begin
`ifdef FETCH_STACK_CHECK_EN
          if (sp_q == SP_FULL) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_inc;
            pc_d    = pc_rel;
            state_d = FETCH;
          end
`else
          push_en = 1'b1;
          sp_d    = sp_inc;
          pc_d    = pc_rel;
          state_d = FETCH;
`endif
        end else if (is_rts) begin
`ifdef FETCH_STACK_CHECK_EN
          if (sp_q == '0) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            sp_d    = sp_dec;
            pc_d    = stack_q[pop_idx];
            state_d = FETCH;
          end
`else
          sp_d    = sp_dec;
          pc_d    = stack_q[pop_idx];
          state_d = FETCH;
`endif
        end else begin
          instr_d       = ram_data;
          instr_pc_d    = pc_q;
          pc_d          = pc_inc;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= '0;
      sp_q          <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_STACK_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      sp_q          <= sp_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_STACK_CHECK_EN
      fault_q       <= fault_d;
`endif
    end
  end

  // NOTE: the return stack is deliberately not reset; sp alone defines which
  // entries are meaningful, and leaving the array resetless lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a one-cycle-latency program RAM model.
// Honours FETCH_STACK_CHECK_EN for the stack over/underflow scenario.
module tb_fetch_unit;

  localparam logic [21:0] W_NOP = 22'h008000;
  localparam logic [21:0] W_RTS = 22'h018000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [10:0] ram_addr;
  logic        ram_rd_enb;
  logic [21:0] ram_data = '0;
  logic [21:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [9:0]  instr_pc;
  logic        fault;

  logic [21:0] mem [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ram_addr   (ram_addr),
    .ram_rd_enb (ram_rd_enb),
    .ram_data   (ram_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_pc   (instr_pc),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Program RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ram_rd_enb) ram_data <= mem[ram_addr];
  end

  // Sample point: just after the falling edge, well away from the active edge.
  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 2048; i++) mem[i] = 22'h000000;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en = 1'b0;
    instr_ready = 1'b1;
    next_cycle;
    next_cycle;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    clear_mem;
    rst = 1'b1;
    en = 1'b1;
    instr_ready = 1'b1;
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL reset_rd_during_rst: got %0b want 0", ram_rd_enb); end
    n_cmp++; if (ram_addr !== 11'd0) begin n_err++; $display("FAIL reset_addr_during_rst: got %0d want 0", ram_addr); end
    rst = 1'b0;
    en = 1'b0;
    #1;
    n_cmp++; if (ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL reset_rd_idle: got %0b want 0", ram_rd_enb); end
    n_cmp++; if (ram_addr !== 11'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    n_cmp++; if (instr !== 22'h0) begin n_err++; $display("FAIL reset_instr: got %0h want 0", instr); end
    n_cmp++; if (instr_pc !== 10'd0) begin n_err++; $display("FAIL reset_instr_pc: got %0d want 0", instr_pc); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %0b want 0", fault); end
    // en low keeps the unit idle in FETCH.
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL idle_no_fetch: got %0b want 0", ram_rd_enb); end
  endtask

  task automatic test_sequential_and_jmp;
    clear_mem;
    mem[0] = W_NOP;
    mem[1] = W_NOP;
    mem[2] = W_NOP;
    mem[3] = 22'h200600;
    mem[6] = 22'h0000AA;
    do_reset;
    en = 1'b1;
    #1;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd0) begin n_err++; $display("FAIL seq_fetch0: got rd=%0b addr=%0d want rd=1 addr=0", ram_rd_enb, ram_addr); end
    for (int i = 0; i < 3; i++) begin
      next_cycle;
      n_cmp++; if (ram_rd_enb !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_decode%0d: got rd=%0b valid=%0b want 0 0", i, ram_rd_enb, instr_valid); end
      next_cycle;
      n_cmp++; if (instr_valid !== 1'b1 || ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL seq_issue%0d: got valid=%0b rd=%0b want 1 0", i, instr_valid, ram_rd_enb); end
      n_cmp++; if (instr !== W_NOP) begin n_err++; $display("FAIL seq_instr%0d: got %0h want %0h", i, instr, W_NOP); end
      n_cmp++; if (instr_pc !== 10'(i)) begin n_err++; $display("FAIL seq_instr_pc%0d: got %0d want %0d", i, instr_pc, i); end
      next_cycle;
      n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'(i + 1)) begin n_err++; $display("FAIL seq_fetch%0d: got rd=%0b addr=%0d want rd=1 addr=%0d", i + 1, ram_rd_enb, ram_addr, i + 1); end
    end
    next_cycle;
    n_cmp++; if (instr_valid !== 1'b0 || ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL jmp_decode: got valid=%0b rd=%0b want 0 0", instr_valid, ram_rd_enb); end
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd6) begin n_err++; $display("FAIL jmp_target: got rd=%0b addr=%0d want rd=1 addr=6", ram_rd_enb, ram_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL jmp_not_issued: got %0b want 0", instr_valid); end
    next_cycle;
    next_cycle;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 22'h0000AA || instr_pc !== 10'd6) begin n_err++; $display("FAIL jmp_issue: got valid=%0b instr=%0h pc=%0d want 1 aa 6", instr_valid, instr, instr_pc); end
    en = 1'b0;
  endtask

  task automatic test_bsr_rts;
    clear_mem;
    mem[0]  = 22'h200800;
    mem[8]  = 22'h1C0400;
    mem[12] = W_RTS;
    mem[9]  = 22'h000055;
    do_reset;
    en = 1'b1;
    #1;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd0) begin n_err++; $display("FAIL bsr_fetch0: got rd=%0b addr=%0d want 1 0", ram_rd_enb, ram_addr); end
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd8) begin n_err++; $display("FAIL bsr_fetch8: got rd=%0b addr=%0d want 1 8", ram_rd_enb, ram_addr); end
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd12) begin n_err++; $display("FAIL bsr_target: got rd=%0b addr=%0d want 1 12", ram_rd_enb, ram_addr); end
    n_cmp++; if (dut.sp_q !== 4'd1) begin n_err++; $display("FAIL bsr_sp: got %0d want 1", dut.sp_q); end
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd9) begin n_err++; $display("FAIL rts_target: got rd=%0b addr=%0d want 1 9", ram_rd_enb, ram_addr); end
    n_cmp++; if (dut.sp_q !== 4'd0) begin n_err++; $display("FAIL rts_sp: got %0d want 0", dut.sp_q); end
    next_cycle;
    next_cycle;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 22'h000055 || instr_pc !== 10'd9) begin n_err++; $display("FAIL rts_issue: got valid=%0b instr=%0h pc=%0d want 1 55 9", instr_valid, instr, instr_pc); end
    en = 1'b0;
  endtask

  task automatic test_wrap;
    clear_mem;
    mem[0]    = 22'h23E800;
    mem[1000] = 22'h1CBA00;
    mem[162]  = W_RTS;
    mem[1001] = 22'h23FF00;
    mem[1023] = 22'h000011;
    do_reset;
    en = 1'b1;
    #1;
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd1000) begin n_err++; $display("FAIL wrap_fetch1000: got rd=%0b addr=%0d want 1 1000", ram_rd_enb, ram_addr); end
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd162) begin n_err++; $display("FAIL wrap_bsr_target: got rd=%0b addr=%0d want 1 162", ram_rd_enb, ram_addr); end
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd1001) begin n_err++; $display("FAIL wrap_rts_target: got rd=%0b addr=%0d want 1 1001", ram_rd_enb, ram_addr); end
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd1023) begin n_err++; $display("FAIL wrap_fetch1023: got rd=%0b addr=%0d want 1 1023", ram_rd_enb, ram_addr); end
    next_cycle;
    next_cycle;
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 10'd1023 || instr !== 22'h000011) begin n_err++; $display("FAIL wrap_issue: got valid=%0b pc=%0d instr=%0h want 1 1023 11", instr_valid, instr_pc, instr); end
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd0) begin n_err++; $display("FAIL wrap_pc_rollover: got rd=%0b addr=%0d want 1 0", ram_rd_enb, ram_addr); end
    en = 1'b0;
  endtask

  task automatic test_stall;
    clear_mem;
    mem[0] = 22'h0ABCDE;
    mem[1] = 22'h000001;
    do_reset;
    en = 1'b1;
    instr_ready = 1'b0;
    #1;
    next_cycle;
    // Dropping en mid-instruction must not abort it.
    en = 1'b0;
    next_cycle;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 22'h0ABCDE || instr_pc !== 10'd0) begin n_err++; $display("FAIL stall_hold%0d: got valid=%0b instr=%0h pc=%0d want 1 abcde 0", k, instr_valid, instr, instr_pc); end
      n_cmp++; if (ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL stall_rd%0d: got %0b want 0", k, ram_rd_enb); end
      next_cycle;
    end
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 22'h0ABCDE) begin n_err++; $display("FAIL stall_before_ready: got valid=%0b instr=%0h want 1 abcde", instr_valid, instr); end
    instr_ready = 1'b1;
    en = 1'b1;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_resume: got rd=%0b addr=%0d valid=%0b want 1 1 0", ram_rd_enb, ram_addr, instr_valid); end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_issue;
    clear_mem;
    mem[0] = 22'h0ABCDE;
    do_reset;
    en = 1'b1;
    instr_ready = 1'b0;
    #1;
    next_cycle;
    next_cycle;
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %0b want 1", instr_valid); end
    rst = 1'b1;
    next_cycle;
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 22'h0 || instr_pc !== 10'd0) begin n_err++; $display("FAIL midrst_outputs: got valid=%0b instr=%0h pc=%0d want 0 0 0", instr_valid, instr, instr_pc); end
    n_cmp++; if (ram_rd_enb !== 1'b0 || ram_addr !== 11'd0) begin n_err++; $display("FAIL midrst_rd: got rd=%0b addr=%0d want 0 0", ram_rd_enb, ram_addr); end
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd0) begin n_err++; $display("FAIL midrst_refetch: got rd=%0b addr=%0d want 1 0", ram_rd_enb, ram_addr); end
    en = 1'b0;
  endtask

  task automatic test_stack_limits;
`ifdef FETCH_STACK_CHECK_EN
    // Nine chained BSR +1: the ninth finds the stack full.
    clear_mem;
    for (int i = 0; i < 9; i++) mem[i] = 22'h1C0100;
    do_reset;
    en = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'(i)) begin n_err++; $display("FAIL ovf_fetch%0d: got rd=%0b addr=%0d want 1 %0d", i, ram_rd_enb, ram_addr, i); end
      if (i < 8) begin
        next_cycle;
        next_cycle;
      end
    end
    next_cycle;
    next_cycle;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (fault !== 1'b1 || ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL ovf_fault%0d: got fault=%0b rd=%0b want 1 0", k, fault, ram_rd_enb); end
      next_cycle;
    end
    n_cmp++; if (dut.sp_q !== 4'd8 || dut.pc_q !== 10'd8) begin n_err++; $display("FAIL ovf_state: got sp=%0d pc=%0d want 8 8", dut.sp_q, dut.pc_q); end
    rst = 1'b1;
    next_cycle;
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL ovf_rst_clear: got %0b want 0", fault); end
    rst = 1'b0;

    clear_mem;
    mem[0] = W_RTS;
    do_reset;
    en = 1'b1;
    #1;
    next_cycle;
    next_cycle;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (fault !== 1'b1 || ram_rd_enb !== 1'b0) begin n_err++; $display("FAIL udf_fault%0d: got fault=%0b rd=%0b want 1 0", k, fault, ram_rd_enb); end
      next_cycle;
    end
    n_cmp++; if (dut.sp_q !== 4'd0 || dut.pc_q !== 10'd0) begin n_err++; $display("FAIL udf_state: got sp=%0d pc=%0d want 0 0", dut.sp_q, dut.pc_q); end
    en = 1'b0;
`else
    // Eight pushes wrap sp back to 0 and leave stack[7] = 8; RTS then underflows onto it.
    clear_mem;
    for (int i = 0; i < 7; i++) mem[i] = 22'h1C0100;
    mem[7]   = 22'h1C6400;
    mem[107] = W_RTS;
    mem[8]   = 22'h000099;
    do_reset;
    en = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'(i)) begin n_err++; $display("FAIL wrapstk_fetch%0d: got rd=%0b addr=%0d want 1 %0d", i, ram_rd_enb, ram_addr, i); end
      next_cycle;
      next_cycle;
    end
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd107 || dut.sp_q !== 4'd0) begin n_err++; $display("FAIL wrapstk_rts_fetch: got rd=%0b addr=%0d sp=%0d want 1 107 0", ram_rd_enb, ram_addr, dut.sp_q); end
    next_cycle;
    next_cycle;
    n_cmp++; if (ram_rd_enb !== 1'b1 || ram_addr !== 11'd8) begin n_err++; $display("FAIL wrapstk_rts_target: got rd=%0b addr=%0d want 1 8", ram_rd_enb, ram_addr); end
    n_cmp++; if (dut.sp_q !== 4'd7) begin n_err++; $display("FAIL wrapstk_sp: got %0d want 7", dut.sp_q); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL wrapstk_fault: got %0b want 0", fault); end
    next_cycle;
    next_cycle;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 22'h000099 || instr_pc !== 10'd8) begin n_err++; $display("FAIL wrapstk_issue: got valid=%0b instr=%0h pc=%0d want 1 99 8", instr_valid, instr, instr_pc); end
    en = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    instr_ready = 1'b1;
    test_reset;
    test_sequential_and_jmp;
    test_bsr_rts;
    test_wrap;
    test_stall;
    test_reset_mid_issue;
    test_stack_limits;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 22, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 11, meaning program-RAM address width.
REQ-003 SHALL have parameter STACK_DEPTH, default 8, meaning return-address stack entries.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port en  input  1  run enable; a new fetch starts only when high.
REQ-007 SHALL have port ram_addr  output  ADDR_SIZE  program-RAM address; bit 10 always 0.
REQ-008 SHALL have port ram_rd_enb  output  1  program-RAM read strobe.
REQ-009 SHALL have port ram_data  input  RAM_WIDTH  program-RAM read data, valid one cycle after ram_rd_enb.
REQ-010 SHALL have port instr  output  RAM_WIDTH  instruction presented downstream.
REQ-011 SHALL have port instr_valid  output  1  instr and instr_pc valid.
REQ-012 SHALL have port instr_ready  input  1  downstream accepts instr.
REQ-013 SHALL have port instr_pc  output  10  address the presented instr was fetched from.
REQ-014 SHALL have port fault  output  1  sticky return-stack fault.

Function
REQ-015 SHALL hold a 10-bit pc, a STACK_DEPTH x 10-bit return stack and a stack pointer sp of 0..STACK_DEPTH.
REQ-016 SHALL decode opcode = instr[21:18] and field = instr[17:8]; sub = instr[17:15] when opcode is 4'b0000.
REQ-017 SHALL run FSM states FETCH, DECODE, ISSUE, FAULT.
REQ-018 FETCH: if en, drive ram_rd_enb=1 and ram_addr={1'b0,pc} for exactly one cycle, go DECODE; else ram_rd_enb=0, stay.
REQ-019 DECODE: capture ram_data; JMP (opcode 4'b1000): pc <= field, go FETCH, no issue.
REQ-020 DECODE: BSR (opcode 4'b0111): push pc+1, sp <= sp+1, pc <= (pc+field) mod 1024, go FETCH, no issue.
REQ-021 DECODE: RTS (opcode 4'b0000, sub 3'b011): sp <= sp-1, pc <= stack[sp-1], go FETCH, no issue.
REQ-022 DECODE: any other word: instr <= ram_data, instr_pc <= pc, pc <= pc+1 mod 1024, go ISSUE.
REQ-023 ISSUE: instr_valid=1; instr and instr_pc SHALL stay stable until instr_ready=1 is sampled; then go FETCH with instr_valid=0 next cycle.
REQ-024 ram_rd_enb SHALL be 0 in DECODE, ISSUE and FAULT.
REQ-025 Latency: non-control word issued 2 cycles after its fetch cycle; control-flow word costs 2 cycles total.
REQ-026 pc+1 and pc+field SHALL wrap modulo 1024; 1023+1 = 0.
REQ-027 en low during DECODE or ISSUE SHALL NOT abort the current instruction.

Reset
REQ-028 rst SHALL force state FETCH, pc=0, sp=0, instr=0, instr_pc=0, instr_valid=0, ram_rd_enb=0, ram_addr=0, fault=0.
REQ-029 rst SHALL take priority over every other event, including mid-DECODE or mid-ISSUE; stack contents need not be cleared.

Configuration
REQ-030 Macro FETCH_STACK_CHECK_EN defined: BSR with sp==STACK_DEPTH or RTS with sp==0 SHALL enter FAULT, set fault=1, leave pc/sp unchanged, and hold until rst.
REQ-031 Macro FETCH_STACK_CHECK_EN undefined: sp SHALL wrap modulo STACK_DEPTH (overwrite oldest/read stack[STACK_DEPTH-1]), fault SHALL be constant 0, FAULT unreachable.

Verification
REQ-032 Reset, words 0..2 = 0x008000, instr_ready=1 -> ram_addr 0,1,2 every 3 cycles; instr_pc 0,1,2; instr=0x008000.
REQ-033 Word 3 = 0x200600 (JMP 6) -> next ram_addr 6; word 3 never appears with instr_valid.
REQ-034 Word 8 = 0x1C0400 (BSR +4), word 12 = 0x018000 (RTS) -> fetch 12 with sp=1, then fetch 9 with sp=0.
REQ-035 BSR field 186 at pc 1000 -> next ram_addr 162; RTS returns to 1001.
REQ-036 instr_ready held 0 for 5 cycles in ISSUE -> instr/instr_pc stable, ram_rd_enb=0, fetch resumes cycle after ready=1.
REQ-037 RTS with sp=0 -> macro defined: fault=1, no further ram_rd_enb until rst; undefined: fault=0, sp=7, pc=stack[7].
